// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and op classification for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_MUL   = 4'b1000;
  localparam logic [3:0] ALU_UDIV  = 4'b1001;
  localparam logic [3:0] ALU_SDIV  = 4'b1010;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  function automatic logic is_long_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_UDIV) || (op == ALU_SDIV);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the execute-stage controller and alu_seq.
interface alu_seq_if #(
  parameter int N = 64
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   ALUControl;
  logic [N-1:0] result;
  logic         zero;
  logic         negative;
  logic         carry;
  logic         overflow;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, a, b, ALUControl,
    input  result, zero, negative, carry, overflow, busy, done, div_by_zero
  );

  modport slave (
    input  start, a, b, ALUControl,
    output result, zero, negative, carry, overflow, busy, done, div_by_zero
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// One-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// The load cycle already performs the first iteration, so N edges yield the answer.
module seq_muldiv #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         op_div,
  input  logic [N-1:0] opa,
  input  logic [N-1:0] opb,
  output logic [N-1:0] res
);

  // acc: product accumulator (mul) or partial remainder (div)
  // x:   shifting multiplicand (mul) or dividend-in / quotient-out (div)
  // y:   shifting multiplier (mul) or fixed divisor (div)
  logic         div_q;
  logic [N-1:0] acc, x, y;
  logic         cur_div;
  logic [N-1:0] cur_acc, cur_x, cur_y;
  logic [N-1:0] acc_nxt, x_nxt, y_nxt;
  logic [N:0]   rem_sh;
  logic         take;

  always_comb begin
    cur_div = load ? op_div : div_q;
    cur_acc = load ? '0     : acc;
    cur_x   = load ? opa    : x;
    cur_y   = load ? opb    : y;
    rem_sh  = {cur_acc, cur_x[N-1]};
    take    = 1'b0;
    acc_nxt = cur_acc;
    x_nxt   = cur_x;
    y_nxt   = cur_y;
    if (cur_div) begin
      take    = rem_sh >= {1'b0, cur_y};
      acc_nxt = take ? N'(rem_sh - {1'b0, cur_y}) : rem_sh[N-1:0];
      x_nxt   = {cur_x[N-2:0], take};
    end else begin
      acc_nxt = cur_y[0] ? (cur_acc + cur_x) : cur_acc;
      x_nxt   = cur_x << 1;
      y_nxt   = cur_y >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) div_q <= 1'b0;
    else       div_q <= cur_div;
  end

  always_ff @(posedge clk) begin
    acc <= acc_nxt;
    x   <= x_nxt;
    y   <= y_nxt;
  end

  assign res = div_q ? x : acc;

endmodule

// File: rtl/alu_seq.sv
// Registered N-bit ALU: single-cycle logic/add/sub ops plus iterative MUL/UDIV/SDIV,
// with a start/done handshake, NZCV flags and a divide-by-zero flag.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N = 64
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  localparam int           CNT_W   = $clog2(N) + 1;
  localparam logic [N-1:0] MIN_INT = {1'b1, {(N-1){1'b0}}};

  function automatic logic [N-1:0] magnitude(input logic signed [N-1:0] v);
    return (v < 0) ? N'('0 - v) : N'(v);
  endfunction

  function automatic logic [N-1:0] apply_sign(input logic [N-1:0] mag, input logic neg);
    return neg ? N'('0 - mag) : mag;
  endfunction

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         op_q;
  logic               neg_q, ovf_q;

  logic signed [N-1:0] a_s, b_s;
  logic                accept, div0, long_op, md_load, md_div;
  logic [N-1:0]        md_opa, md_opb, md_res, fin_res;
  logic [N:0]          sum, dif;
  logic [N-1:0]        short_res;
  logic                short_c, short_v, short_dz;

  logic [N-1:0]        result_q;
  logic                zero_q, negative_q, carry_q, overflow_q, dz_q;

  assign a_s     = bus.a;
  assign b_s     = bus.b;
  assign accept  = bus.start && (state != EXEC);
  assign div0    = ((bus.ALUControl == ALU_UDIV) || (bus.ALUControl == ALU_SDIV)) && (bus.b == '0);
  assign long_op = is_long_op(bus.ALUControl) && !div0;
  assign md_load = accept && long_op;
  assign md_div  = (bus.ALUControl != ALU_MUL);
  assign md_opa  = (bus.ALUControl == ALU_SDIV) ? magnitude(a_s) : bus.a;
  assign md_opb  = (bus.ALUControl == ALU_SDIV) ? magnitude(b_s) : bus.b;

  // Subtraction as a + ~b + 1 so bit N reads directly as not-borrow.
  assign sum = {1'b0, bus.a} + {1'b0, bus.b};
  assign dif = {1'b0, bus.a} + {1'b0, ~bus.b} + (N+1)'(1);

  always_comb begin
    short_res = '0;
    short_c   = 1'b0;
    short_v   = 1'b0;
    short_dz  = 1'b0;
    case (bus.ALUControl)
      ALU_AND:   short_res = bus.a & bus.b;
      ALU_OR:    short_res = bus.a | bus.b;
      ALU_ADD: begin
        short_res = sum[N-1:0];
        short_c   = sum[N];
        short_v   = (bus.a[N-1] == bus.b[N-1]) && (sum[N-1] != bus.a[N-1]);
      end
      ALU_SUB: begin
        short_res = dif[N-1:0];
        short_c   = dif[N];
        short_v   = (bus.a[N-1] != bus.b[N-1]) && (dif[N-1] != bus.a[N-1]);
      end
      ALU_PASSB: short_res = bus.b;
      ALU_UDIV, ALU_SDIV: begin
        short_res = '1;
        short_dz  = 1'b1;
      end
      default:   short_res = '0;
    endcase
  end

  seq_muldiv #(.N(N)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load),
    .op_div (md_div),
    .opa    (md_opa),
    .opb    (md_opb),
    .res    (md_res)
  );

  assign fin_res = (op_q == ALU_SDIV) ? apply_sign(md_res, neg_q) : md_res;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start) state_nxt = long_op ? EXEC : DONE;
        else           state_nxt = IDLE;
      end
      EXEC:    if (cnt == CNT_W'(1)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operation context captured at accept, consumed when the iteration finishes.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= bus.ALUControl;
      neg_q <= bus.a[N-1] ^ bus.b[N-1];
      ovf_q <= (bus.ALUControl == ALU_SDIV) && (bus.a == MIN_INT) && (bus.b == '1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      dz_q       <= 1'b0;
    end else if (accept) begin
      cnt  <= CNT_W'(N);
      dz_q <= !long_op && short_dz;
      if (!long_op) begin
        result_q   <= short_res;
        zero_q     <= (short_res == '0);
        negative_q <= short_res[N-1];
        carry_q    <= short_c;
        overflow_q <= short_v;
      end
    end else if (state == EXEC) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        result_q   <= fin_res;
        zero_q     <= (fin_res == '0);
        negative_q <= fin_res[N-1];
        carry_q    <= 1'b0;
        overflow_q <= ovf_q;
      end
    end
  end

  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.negative    = negative_q;
  assign bus.carry       = carry_q;
  assign bus.overflow    = overflow_q;
  assign bus.div_by_zero = dz_q;
  assign bus.busy        = (state == EXEC);
  assign bus.done        = (state == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: N=64 instance checked against a behavioural model,
// N=8 instance checked for the MIN_INT / -1 corner and small-width latency.
module tb_alu_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cycle = 0;
  int   total = 0;
  int   bad = 0;
  int   busy_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  alu_seq_if #(.N(64)) bus64 ();
  alu_seq_if #(.N(8))  bus8 ();

  alu_seq #(.N(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64));
  alu_seq #(.N(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_PASSB = 4'b0111, OP_MUL = 4'b1000,
                         OP_UDIV = 4'b1001, OP_SDIV = 4'b1010, OP_BAD = 4'b1111;

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic [4:0]  fl;    // {n, z, c, v, dz}
    int          due;
    int          busy;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [3:0] op,
                                 input logic [63:0] a, input logic [63:0] b, input int k);
    exp_t        e;
    logic [64:0] w;
    logic [63:0] r;
    logic        c, v, dz;
    int          lat;
    r = '0; c = 0; v = 0; dz = 0; lat = 1; w = '0;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[63:0]; c = w[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      OP_SUB: begin
        w = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r = w[63:0]; c = w[64];
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      OP_PASSB: r = b;
      OP_MUL: begin r = a * b; lat = 65; end
      OP_UDIV: begin
        if (b == 0) begin r = '1; dz = 1; end
        else begin r = a / b; lat = 65; end
      end
      OP_SDIV: begin
        if (b == 0) begin r = '1; dz = 1; end
        else if (a == 64'h8000_0000_0000_0000 && b == '1) begin r = a; v = 1; lat = 65; end
        else begin r = $signed(a) / $signed(b); lat = 65; end
      end
      default:  r = '0;
    endcase
    e.tag  = tag;
    e.res  = r;
    e.fl   = {r[63], (r == 0), c, v, dz};
    e.due  = k + lat;
    e.busy = (lat == 1) ? 0 : 64;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (bus64.busy) busy_cnt++;
      if (bus64.done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk({e.tag, "_res"}, bus64.result, e.res);
          chk({e.tag, "_flags"}, {59'd0, bus64.negative, bus64.zero, bus64.carry,
                                  bus64.overflow, bus64.div_by_zero}, {59'd0, e.fl});
          chk({e.tag, "_cycle"}, 64'(cycle), 64'(e.due));
          chk({e.tag, "_busy"}, 64'(busy_cnt), 64'(e.busy));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic drive64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bus64.start = 1'b1;
    bus64.ALUControl = op;
    bus64.a = a;
    bus64.b = b;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b);
    @(posedge clk); #1;
    drive64(op, a, b);
    exp_q.push_back(model(tag, op, a, b, cycle));
    @(posedge clk); #1;
    bus64.start = 1'b0;
    wait_drain();
  endtask

  task automatic run8(input string tag, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] er, input logic [4:0] efl,
                      input int elat);
    int k;
    int n;
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.ALUControl = op; bus8.a = a; bus8.b = b;
    k = cycle;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus8.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_cycle"}, 64'(cycle - k), 64'(elat));
    chk({tag, "_res"}, {56'd0, bus8.result}, {56'd0, er});
    chk({tag, "_flags"}, {59'd0, bus8.negative, bus8.zero, bus8.carry, bus8.overflow,
                          bus8.div_by_zero}, {59'd0, efl});
  endtask

  initial begin
    logic [3:0]  ops [9];
    logic [63:0] ra, rb;
    logic [3:0]  rop;
    int          k;
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB, OP_MUL, OP_UDIV, OP_SDIV, OP_BAD};

    bus64.start = 1'b0; bus64.a = '0; bus64.b = '0; bus64.ALUControl = '0;
    bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.ALUControl  = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_result", bus64.result, 64'd0);
    chk("rst_done", {63'd0, bus64.done}, 64'd0);
    chk("rst_busy", {63'd0, bus64.busy}, 64'd0);
    chk("rst_flags", {59'd0, bus64.negative, bus64.zero, bus64.carry, bus64.overflow,
                      bus64.div_by_zero}, 64'd0);
    chk("rst8_result", {56'd0, bus8.result}, 64'd0);

    run_op("add_239_26", OP_ADD, 64'd239, 64'd26);
    run_op("sub_26_239", OP_SUB, 64'd26, 64'd239);
    run_op("sub_0_m635", OP_SUB, 64'd0, -64'sd635);
    run_op("add_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    run_op("add_carry", OP_ADD, '1, 64'd1);
    run_op("and", OP_AND, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);
    run_op("passb", OP_PASSB, 64'd5, 64'h8000_0000_0000_0001);
    run_op("bad_op", OP_BAD, 64'd5, 64'd7);

    // MUL with ignored start pulses while busy
    @(posedge clk); #1;
    drive64(OP_MUL, 64'd239, 64'd26);
    exp_q.push_back(model("mul_239_26", OP_MUL, 64'd239, 64'd26, cycle));
    @(posedge clk); #1 bus64.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 drive64(OP_ADD, 64'd1, 64'd2);
    @(posedge clk); #1 bus64.start = 1'b0;
    repeat (20) @(posedge clk);
    #1 drive64(OP_UDIV, 64'd9, 64'd0);
    @(posedge clk); #1 bus64.start = 1'b0;
    wait_drain();

    run_op("sdiv_m98_7", OP_SDIV, -64'sd98, 64'd7);
    run_op("udiv_930_0", OP_UDIV, 64'd930, 64'd0);
    run_op("add_clr_dz", OP_ADD, 64'd5, 64'd6);
    run_op("sdiv_min_m1", OP_SDIV, 64'h8000_0000_0000_0000, '1);
    run_op("udiv_big", OP_UDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    run_op("mul_neg", OP_MUL, -64'sd7, 64'd9);

    // back-to-back: start held into DONE
    @(posedge clk); #1;
    drive64(OP_ADD, 64'd1, 64'd1);
    exp_q.push_back(model("b2b_add", OP_ADD, 64'd1, 64'd1, cycle));
    @(posedge clk); #1;
    drive64(OP_OR, 64'd593, 64'd0);
    exp_q.push_back(model("b2b_or", OP_OR, 64'd593, 64'd0, cycle));
    @(posedge clk); #1 bus64.start = 1'b0;
    wait_drain();

    for (int i = 0; i < 8; i++) begin
      rop = ops[$urandom_range(0, 8)];
      ra  = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0:       rb = 64'($urandom_range(1, 1000));
        1:       rb = 64'd0;
        2:       rb = -64'($urandom_range(1, 50));
        default: rb = {$urandom(), $urandom()};
      endcase
      run_op($sformatf("rnd%0d", i), rop, ra, rb);
    end

    // reset 20 cycles into a MUL: no done may follow
    @(posedge clk); #1;
    drive64(OP_MUL, 64'd12345, 64'd678);
    k = cycle;
    @(posedge clk); #1 bus64.start = 1'b0;
    while (cycle < k + 20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_busy", {63'd0, bus64.busy}, 64'd0);
    chk("abort_result", bus64.result, 64'd0);
    chk("abort_done", {63'd0, bus64.done}, 64'd0);
    repeat (70) @(posedge clk);
    run_op("post_abort", OP_SUB, 64'd100, 64'd1);

    run8("n8_sdiv_min", OP_SDIV, 8'h80, 8'hFF, 8'h80, 5'b10010, 9);
    run8("n8_mul", OP_MUL, 8'd13, 8'd11, 8'h8F, 5'b10000, 9);
    run8("n8_udiv", OP_UDIV, 8'd200, 8'd7, 8'd28, 5'b00000, 9);
    run8("n8_sdiv", OP_SDIV, 8'hF9, 8'h02, 8'hFD, 5'b10000, 9);
    run8("n8_add_ovf", OP_ADD, 8'h7F, 8'h01, 8'h80, 5'b10010, 1);
    run8("n8_div0", OP_SDIV, 8'h05, 8'h00, 8'hFF, 5'b10001, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational 64-bit ALU.
- Executes the existing single-cycle ops (AND, OR, ADD, SUB, PASSB) plus iterative MUL, UDIV and SDIV.
- Uses a start/done handshake, full NZCV flags and a divide-by-zero exception flag.
- Sits in the execute stage of the multi-cycle / exception-capable core; the controller stalls on busy.

Parameters:
- N, 64, operand/result width (≥ 4).
- CNT_W, $clog2(N)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  N  operand A.
- b  in  N  operand B.
- ALUControl  in  4  operation code, sampled with start.
- result  out  N  registered result, held until the next accepted start.
- zero  out  1  result == 0.
- negative  out  1  result[N-1].
- carry  out  1  carry out / not-borrow.
- overflow  out  1  signed overflow.
- busy  out  1  iterative op in progress.
- done  out  1  one-cycle pulse: result and flags valid.
- div_by_zero  out  1  exception flag, valid with done.

Behaviour:
- Encoding: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 0111 PASSB, 1000 MUL (low N bits of a*b), 1001 UDIV, 1010 SDIV.
- Any other code completes as a short op with result=0, zero=1 and all other flags 0.
- Reset, checked first every edge:
  - state=IDLE; result, all flags, busy, done = 0.
  - An operation in flight is aborted with no done.
- FSM states: IDLE, EXEC, DONE.
- IDLE/DONE with start=1:
  - Latch a, b, ALUControl.
  - Short op, or UDIV/SDIV with b=0: go to DONE next cycle; done=1 exactly one cycle after start.
  - MUL/UDIV/SDIV otherwise: go to EXEC with counter=N.
- IDLE/DONE with start=0: go to / stay in IDLE; done=0; outputs hold.
- EXEC:
  - busy=1; one bit per cycle; counter decrements.
  - At counter=1, go to DONE.
  - done asserts N+1 cycles after the start edge.
  - start is ignored in EXEC.
- DONE: done=1 for one cycle. start in DONE is accepted (back-to-back, no idle bubble).
- MUL: shift-add, unsigned. Low N bits are identical for signed operands. C=V=0.
- UDIV: restoring division, quotient in result, remainder discarded. C=V=0.
- SDIV:
  - Divide magnitudes, then negate the quotient if sign(a)≠sign(b); truncates toward zero.
  - a=MIN_INT, b=-1: result=MIN_INT, overflow=1.
- Divide by zero (UDIV/SDIV, b=0): result all ones, div_by_zero=1, short-op latency, C=V=0.
- ADD flags: carry = bit N of the (N+1)-bit sum; overflow = operands share a sign and the result sign differs.
- SUB flags: computed as a+~b+1; carry=1 means no borrow (a ≥ b unsigned); overflow per signed subtraction.
- AND/OR/PASSB: C=V=0.
- zero and negative are derived from the final result for every op.
- Flags and result update only in the cycle they enter DONE; div_by_zero clears on the next accepted start.

Decomposition:
- Package alu_seq_pkg:
  - ALUControl localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_MUL, ALU_UDIV, ALU_SDIV).
  - State typedef enum logic [1:0] {IDLE, EXEC, DONE}.
- One sub-module, seq_muldiv #(N):
  - Shift-add multiplier / restoring divider datapath.
  - Inputs: clk, reset, load, op_div, dividend/multiplicand, divisor/multiplier.
  - Outputs: product/quotient.
  - Signed pre/post correction stays in alu_seq.

Test Plan:
- N=64, ADD a=239 b=26 start pulse → done exactly 1 cycle later; result=265; N=Z=C=V=0.
- SUB a=26 b=239 → result=-213 (0xFFFF_FFFF_FFFF_FF2B), negative=1, carry=0, overflow=0. SUB a=0 b=-635 → 635, carry=0.
- MUL a=239 b=26:
  - busy=1 for 64 cycles; done at cycle 65; result=6214.
  - start pulses during busy are ignored and the result is unchanged.
- SDIV a=-98 b=7 → -14. UDIV a=930 b=0 → done after 1 cycle, result=all ones, div_by_zero=1. Next accepted ADD clears div_by_zero.
- N=8, SDIV a=0x80 b=0xFF → result=0x80, overflow=1, negative=1, done at cycle 9.
- Reset at cycle 20 of a MUL → no done, busy=0, result=0 next edge.
- Back-to-back: start held in DONE with OR a=593 b=0 → done again next cycle, result=593.
